flash_sample_reader: RTL and testbench
======================================

// Module: flash_sample_reader
// PURPOSE
//  Sample-fetch engine behind the flash audio driver. Reads 32-bit words from the on-board flash (Avalon-MM read master).
//  Each word holds two signed 16-bit PCM samples: [15:0] is played first in forward order, [31:16] second.
//  On every sample_tick it emits the next sample's upper byte on audio_out. Forward/reverse playback with wrap-around.
//  Sits between clock_divider (supplies sample_tick) and the audio output path.
// PARAMETERS
//  ADDR_WIDTH  23        flash word-address width
//  START_ADDR  23'h0     first word of the clip (inclusive)
//  END_ADDR    23'h7FFFF last word of the clip (inclusive); must be >= START_ADDR
// PORTS
//  clk                     in   1   system clock; single clock domain
//  reset                   in   1   asynchronous, active-low reset
//  sample_tick             in   1   one-clk strobe at the playback rate
//  enable                  in   1   1 = consume ticks; 0 = pause, with audio_out held
//  reverse                 in   1   1 = play backwards
//  restart                 in   1   one-clk strobe: return to the clip start for the current direction
//  flash_mem_read          out  1   Avalon read request
//  flash_mem_address       out  AW  Avalon word address
//  flash_mem_byteenable    out  4   constant 4'hF
//  flash_mem_waitrequest   in   1   Avalon stall
//  flash_mem_readdata      in   32  Avalon read data
//  flash_mem_readdatavalid in   1   Avalon read data strobe
//  audio_out               out  8   current sample, bits [15:8] of the selected half
//  sample_valid            out  1   one-clk pulse when audio_out updates
//  underrun                out  1   one-clk pulse when a tick finds no buffered word
// BEHAVIOUR
//  Reset (async assert, sync release):
//   state=IDLE, addr=START_ADDR, flash_mem_read=0, audio_out=0, sample_valid=0, underrun=0, buffer invalid.
//  States:
//   IDLE:  addr = reverse ? END_ADDR : START_ADDR. If enable=1 -> REQ.
//   REQ:   flash_mem_read=1; address stable.
//          waitrequest=1 -> stay in REQ. waitrequest=0 -> read accepted this clk -> WAIT.
//   WAIT:  flash_mem_read=0. On readdatavalid, latch the word, latch dir_q=reverse, and set half = dir_q.
//          half 0 = [15:0], half 1 = [31:16]. Then -> READY.
//   READY: on sample_tick & enable, the next clk brings:
//          - audio_out = word[half*16+15 -: 8] and sample_valid=1.
//          - If this was the word's second half (half==1 fwd / half==0 rev): step addr and go -> REQ.
//          - Otherwise toggle half.
//  Address step: fwd addr==END_ADDR -> START_ADDR, else +1. rev addr==START_ADDR -> END_ADDR, else -1.
//  Direction: sampled only at word load (dir_q).
//   - A mid-word change of reverse completes the current word in the old order.
//   - That word's address step still uses dir_q.
//   - The following word uses the new order.
//  Latency: tick -> audio_out/sample_valid 1 clk. A fresh fetch costs >=2 clk plus flash latency.
//  Prefetch depth is one word: the fetch of word n+1 starts right after word n's last sample.
//  Underrun: sample_tick & enable in REQ/WAIT -> underrun=1 for 1 clk. audio_out held, no sample_valid. The tick is lost.
//  enable=0: ticks ignored. An outstanding Avalon read still completes; the block then parks in READY.
//  restart:
//   - In IDLE/READY: -> IDLE next clk.
//   - In REQ/WAIT: set restart_pend and complete the handshake. The returned word is discarded, then -> IDLE.
//  Simultaneous restart & tick in READY: restart wins, no sample emitted.
//  readdatavalid outside WAIT is ignored. Only one read is ever outstanding.
//  audio_out holds its last value in every state except reset.
// TESTING
//  1. START=0, END=1, word0=32'hA1B2_C3D4, word1=32'h5566_7788, fwd, tick/16clk
//     -> audio_out C3, A1, 77, 55, C3; addresses 0,1,0.
//  2. reverse=1 from IDLE, END=3, word3=32'h1122_3344 -> first read addr 3; audio_out 11 then 33; next read addr 2.
//  3. waitrequest held 5 clk in REQ -> read=1 and address constant for all 6 clk; exactly one readdatavalid consumed.
//  4. Flash latency 40 clk, tick every 10 clk -> underrun pulses on the ticks seen in REQ/WAIT; audio_out unchanged.
//  5. restart in WAIT at addr 5 -> returned word never appears on audio_out; next read at START_ADDR.
//  6. reset driven low mid-READY (async, between edges) -> all outputs 0 immediately.
//     After release with enable=1 -> read at START_ADDR.

Source files
------------

// File: rtl/flash_sample_reader.sv
// Sample-fetch engine: pulls 32-bit words from flash over Avalon-MM and plays
// their two 16-bit halves, one upper byte per sample_tick, forward or reverse.
module flash_sample_reader #(
  parameter int                    ADDR_WIDTH = 23,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = 23'h0,
  parameter logic [ADDR_WIDTH-1:0] END_ADDR   = 23'h7FFFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_tick,
  input  logic                  enable,
  input  logic                  reverse,
  input  logic                  restart,
  output logic                  flash_mem_read,
  output logic [ADDR_WIDTH-1:0] flash_mem_address,
  output logic [3:0]            flash_mem_byteenable,
  input  logic                  flash_mem_waitrequest,
  input  logic [31:0]           flash_mem_readdata,
  input  logic                  flash_mem_readdatavalid,
  output logic [7:0]            audio_out,
  output logic                  sample_valid,
  output logic                  underrun
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_READY} state_t;

  localparam logic [ADDR_WIDTH-1:0] ONE = 1;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] addr, addr_step;
  logic [31:0]           word_q;
  logic                  half, dir_q, restart_pend;
  logic                  tick_en, last_half, discard;

  assign tick_en   = sample_tick & enable;
  assign last_half = dir_q ? ~half : half;
  assign discard   = restart_pend | restart;

  assign flash_mem_read       = (state == S_REQ);
  assign flash_mem_address    = addr;
  assign flash_mem_byteenable = 4'hF;

  // Wrap-around step follows the direction the current word was loaded with.
  always_comb begin
    addr_step = addr;
    if (dir_q)
      addr_step = (addr == START_ADDR) ? END_ADDR : addr - ONE;
    else
      addr_step = (addr == END_ADDR) ? START_ADDR : addr + ONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (!restart && enable) state_next = S_REQ;
      S_REQ:   if (!flash_mem_waitrequest) state_next = S_WAIT;
      S_WAIT:  if (flash_mem_readdatavalid) state_next = discard ? S_IDLE : S_READY;
      S_READY: begin
        if (restart)
          state_next = S_IDLE;
        else if (tick_en && last_half)
          state_next = S_REQ;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // A restart during a fetch lets the handshake finish and drops the word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr         <= START_ADDR;
      word_q       <= '0;
      half         <= 1'b0;
      dir_q        <= 1'b0;
      restart_pend <= 1'b0;
      audio_out    <= '0;
      sample_valid <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      underrun     <= 1'b0;
      case (state)
        S_IDLE: begin
          addr         <= reverse ? END_ADDR : START_ADDR;
          restart_pend <= 1'b0;
        end
        S_REQ, S_WAIT: begin
          if (restart) restart_pend <= 1'b1;
          if (tick_en) underrun <= 1'b1;
          if (state == S_WAIT && flash_mem_readdatavalid) begin
            restart_pend <= 1'b0;
            if (!discard) begin
              word_q <= flash_mem_readdata;
              dir_q  <= reverse;
              half   <= reverse;
            end
          end
        end
        S_READY: begin
          if (!restart && tick_en) begin
            audio_out    <= half ? word_q[31:24] : word_q[15:8];
            sample_valid <= 1'b1;
            if (last_half)
              addr <= addr_step;
            else
              half <= ~half;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_sample_reader.sv
// Scoreboard bench for flash_sample_reader: a small Avalon flash model answers
// reads, expected samples/underruns and read addresses are queued up front.
module tb_flash_sample_reader;

  localparam int AW = 23;

  typedef struct packed {
    logic       is_under;
    logic [7:0] val;
  } evt_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          sample_tick, enable, reverse, restart;
  logic          flash_mem_read;
  logic [AW-1:0] flash_mem_address;
  logic [3:0]    flash_mem_byteenable;
  logic          flash_mem_waitrequest;
  logic [31:0]   flash_mem_readdata;
  logic          flash_mem_readdatavalid;
  logic [7:0]    audio_out;
  logic          sample_valid, underrun;

  evt_t          exp_evt[$];
  logic [AW-1:0] exp_addr[$];
  int            vec_count = 0;
  int            err_count = 0;
  logic [7:0]    held = 8'h00;
  logic [31:0]   mem [0:3];
  int            lat_cfg = 1;
  int            wait_cfg = 0;

  int            cnt = 0, wl = 0;
  logic          pending = 1'b0, in_req = 1'b0;
  logic [AW-1:0] req_addr, paddr;

  always #5 clk = ~clk;

  flash_sample_reader #(
    .ADDR_WIDTH(AW),
    .START_ADDR(23'd0),
    .END_ADDR  (23'd3)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .sample_tick            (sample_tick),
    .enable                 (enable),
    .reverse                (reverse),
    .restart                (restart),
    .flash_mem_read         (flash_mem_read),
    .flash_mem_address      (flash_mem_address),
    .flash_mem_byteenable   (flash_mem_byteenable),
    .flash_mem_waitrequest  (flash_mem_waitrequest),
    .flash_mem_readdata     (flash_mem_readdata),
    .flash_mem_readdatavalid(flash_mem_readdatavalid),
    .audio_out              (audio_out),
    .sample_valid           (sample_valid),
    .underrun               (underrun)
  );

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic push_sample(input logic [7:0] v);
    evt_t e;
    e.is_under = 1'b0;
    e.val      = v;
    exp_evt.push_back(e);
    held = v;
  endtask

  task automatic push_under();
    evt_t e;
    e.is_under = 1'b1;
    e.val      = held;
    exp_evt.push_back(e);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_stimulus(input int gap);
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    wait_clk(gap - 2);
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  // Flash model: waitrequest and readdatavalid change on the falling edge.
  always @(negedge clk) begin
    flash_mem_readdatavalid = 1'b0;
    if (!reset) begin
      pending               = 1'b0;
      in_req                = 1'b0;
      flash_mem_waitrequest = 1'b0;
    end else begin
      if (pending) begin
        cnt--;
        if (cnt == 0) begin
          flash_mem_readdatavalid = 1'b1;
          flash_mem_readdata      = mem[paddr[1:0]];
          pending                 = 1'b0;
        end
      end
      if (flash_mem_read) begin
        if (!in_req) begin
          in_req   = 1'b1;
          wl       = wait_cfg;
          req_addr = flash_mem_address;
        end else begin
          check_output("address stable in REQ", flash_mem_address, req_addr);
        end
        if (wl > 0) begin
          flash_mem_waitrequest = 1'b1;
          wl--;
        end else begin
          flash_mem_waitrequest = 1'b0;
          in_req  = 1'b0;
          pending = 1'b1;
          cnt     = lat_cfg;
          paddr   = flash_mem_address;
          if (exp_addr.size() == 0) begin
            vec_count++;
            err_count++;
            $display("[TB] FAIL unexpected read: got addr %0h, expected no read", flash_mem_address);
          end else begin
            check_output("read address", flash_mem_address, exp_addr.pop_front());
          end
        end
      end else begin
        if (in_req) begin
          vec_count++;
          err_count++;
          $display("[TB] FAIL read held under waitrequest: got read 0, expected 1");
          in_req = 1'b0;
        end
        flash_mem_waitrequest = 1'b0;
      end
    end
  end

  // Monitor: every sample_valid or underrun pulse consumes one expected event.
  always @(negedge clk) begin : monitor
    evt_t e;
    if (reset && (sample_valid || underrun)) begin
      if (exp_evt.size() == 0) begin
        vec_count++;
        err_count++;
        $display("[TB] FAIL unexpected event: got valid=%0b underrun=%0b audio=%0h, expected none",
                 sample_valid, underrun, audio_out);
      end else begin
        e = exp_evt.pop_front();
        check_output("event is underrun", {31'd0, underrun}, {31'd0, e.is_under});
        check_output("audio_out", {24'd0, audio_out}, {24'd0, e.val});
      end
    end
  end

  initial begin
    mem[0] = 32'hA1B2_C3D4;
    mem[1] = 32'h5566_7788;
    mem[2] = 32'hCAFE_BEEF;
    mem[3] = 32'h1122_3344;
    reset = 1'b0;
    sample_tick = 1'b0;
    enable = 1'b0;
    reverse = 1'b0;
    restart = 1'b0;
    flash_mem_waitrequest = 1'b0;
    flash_mem_readdata = 32'h0;
    flash_mem_readdatavalid = 1'b0;
    wait_clk(3);
    check_output("reset audio_out", {24'd0, audio_out}, 32'h0);
    check_output("reset sample_valid", {31'd0, sample_valid}, 32'h0);
    check_output("reset underrun", {31'd0, underrun}, 32'h0);
    check_output("reset read", {31'd0, flash_mem_read}, 32'h0);
    check_output("reset address", {9'd0, flash_mem_address}, 32'h0);
    check_output("byteenable", {28'd0, flash_mem_byteenable}, 32'hF);
    reset = 1'b1;

    // Forward playback across all four words, wrapping back to word 0.
    $display("[TB] forward playback");
    foreach (exp_addr[i]) ;
    exp_addr.push_back(23'd0); exp_addr.push_back(23'd1); exp_addr.push_back(23'd2);
    exp_addr.push_back(23'd3); exp_addr.push_back(23'd0);
    push_sample(8'hC3); push_sample(8'hA1); push_sample(8'h77); push_sample(8'h55);
    push_sample(8'hBE); push_sample(8'hCA); push_sample(8'h33); push_sample(8'h11);
    push_sample(8'hC3);
    enable = 1'b1;
    wait_clk(8);
    for (int i = 0; i < 9; i++) apply_stimulus(16);

    // Reverse from the clip end, wrapping from word 0 to word 3.
    $display("[TB] reverse playback");
    exp_addr.push_back(23'd3); exp_addr.push_back(23'd2); exp_addr.push_back(23'd1);
    exp_addr.push_back(23'd0); exp_addr.push_back(23'd3);
    push_sample(8'h11); push_sample(8'h33); push_sample(8'hCA); push_sample(8'hBE);
    push_sample(8'h55); push_sample(8'h77); push_sample(8'hA1); push_sample(8'hC3);
    push_sample(8'h11);
    reverse = 1'b1;
    pulse_restart();
    wait_clk(8);
    for (int i = 0; i < 9; i++) apply_stimulus(16);

    // Direction flipped mid-word: word 3 finishes in reverse, then word 2 forward.
    $display("[TB] mid-word direction change");
    reverse = 1'b0;
    exp_addr.push_back(23'd2); exp_addr.push_back(23'd3);
    push_sample(8'h33); push_sample(8'hBE); push_sample(8'hCA);
    for (int i = 0; i < 3; i++) apply_stimulus(16);

    // Waitrequest held for five cycles on the restart fetch.
    $display("[TB] waitrequest stall");
    wait_cfg = 5;
    exp_addr.push_back(23'd0);
    push_sample(8'hC3);
    pulse_restart();
    wait_clk(16);
    wait_cfg = 0;
    apply_stimulus(16);
    exp_addr.push_back(23'd1);
    push_sample(8'hA1);
    apply_stimulus(16);

    // Slow flash: ticks during the fetch are lost as underruns.
    $display("[TB] underrun");
    lat_cfg = 40;
    exp_addr.push_back(23'd0);
    push_under(); push_under(); push_under();
    pulse_restart();
    for (int i = 0; i < 3; i++) apply_stimulus(10);
    wait_clk(20);
    push_sample(8'hC3);
    apply_stimulus(16);

    // Restart while waiting on word 1: that word must never be played.
    $display("[TB] restart during fetch");
    exp_addr.push_back(23'd1);
    push_sample(8'hA1);
    apply_stimulus(10);
    pulse_restart();
    lat_cfg = 1;
    exp_addr.push_back(23'd0);
    wait_clk(50);
    push_sample(8'hC3);
    apply_stimulus(16);

    // Paused ticks are ignored; playback resumes where it left off.
    $display("[TB] pause");
    enable = 1'b0;
    apply_stimulus(16);
    enable = 1'b1;
    exp_addr.push_back(23'd1);
    push_sample(8'hA1);
    apply_stimulus(16);

    // Asynchronous reset between edges while READY.
    $display("[TB] async reset");
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check_output("async reset audio_out", {24'd0, audio_out}, 32'h0);
    check_output("async reset sample_valid", {31'd0, sample_valid}, 32'h0);
    check_output("async reset underrun", {31'd0, underrun}, 32'h0);
    check_output("async reset read", {31'd0, flash_mem_read}, 32'h0);
    check_output("async reset address", {9'd0, flash_mem_address}, 32'h0);
    held = 8'h00;
    wait_clk(3);
    exp_addr.push_back(23'd0);
    reset = 1'b1;
    wait_clk(10);
    push_sample(8'hC3);
    apply_stimulus(16);

    wait_clk(20);
    check_output("events outstanding", exp_evt.size(), 32'd0);
    check_output("reads outstanding", exp_addr.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
